spwm_leg_mux: RTL and testbench

- Parametrised successor of the mono/three-phase output selector.
- Routes one of N_SRC SPWM gate-signal sources onto N_LEGS physical half-bridge legs (H/L pairs).
- Adds glitch-free mode switching: all gates are forced off for a programmable blanking interval before the new source is committed.
- Adds a per-leg shoot-through interlock with a sticky fault, and registered outputs.
- Sits between the pwm/deadtime generators and the gate-driver pins.

---
 rtl/spwm_leg_mux_if.sv | 28 ++
 rtl/spwm_leg_mux.sv | 164 ++++++++++++++++
 tb/tb_spwm_leg_mux.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/spwm_leg_mux_if.sv
// Gate-signal bus between the PWM/deadtime sources and the leg selector.
// master drives the sources and controls; slave is the selector returning the pin-side signals.
interface spwm_leg_mux_if #(
    parameter int N_LEGS = 3,
    parameter int N_SRC  = 2,
    parameter int SEL_W  = 1
);
    logic                      enable;
    logic [SEL_W-1:0]          mode_sel;
    logic [N_SRC*N_LEGS-1:0]   src_h;
    logic [N_SRC*N_LEGS-1:0]   src_l;
    logic                      fault_clr;
    logic [N_LEGS-1:0]         out_h;
    logic [N_LEGS-1:0]         out_l;
    logic [SEL_W-1:0]          active_mode;
    logic                      switching;
    logic                      fault;

    modport master (
        output enable, mode_sel, src_h, src_l, fault_clr,
        input  out_h, out_l, active_mode, switching, fault
    );

    modport slave (
        input  enable, mode_sel, src_h, src_l, fault_clr,
        output out_h, out_l, active_mode, switching, fault
    );
endinterface

// File: rtl/spwm_leg_mux.sv
// Routes one of N_SRC SPWM sources onto N_LEGS half-bridge legs, with blanking on
// every mode change/enable, a per-leg shoot-through interlock and a sticky fault.
module spwm_leg_gate (
    input  logic clk,
    input  logic rst,
    input  logic pass_i,
    input  logic h_i,
    input  logic l_i,
    output logic ovl_o,
    output logic out_h_o,
    output logic out_l_o
);
    logic out_h_q, out_l_q;

    assign ovl_o = h_i & l_i;

    // An overlapping leg is driven low on the very edge the overlap is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_h_q <= 1'b0;
            out_l_q <= 1'b0;
        end else begin
            out_h_q <= pass_i & h_i & ~ovl_o;
            out_l_q <= pass_i & l_i & ~ovl_o;
        end
    end

    assign out_h_o = out_h_q;
    assign out_l_o = out_l_q;
endmodule

module spwm_leg_mux #(
    parameter int N_LEGS       = 3,
    parameter int N_SRC        = 2,
    parameter int SEL_W        = 1,
    parameter int BLANK_CYCLES = 100,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    spwm_leg_mux_if.slave bus
);
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                       state_q;
    logic [SEL_W-1:0]             target_q;
    logic [SEL_W-1:0]             active_q;
    logic [CNT_W-1:0]             cnt_q;
    logic                         switching_q;
    logic                         fault_q;

    logic [N_SRC-1:0][N_LEGS-1:0] src_h_a, src_l_a;
    logic [N_LEGS-1:0]            sel_h, sel_l, ovl;
    logic [N_LEGS-1:0]            out_h_w, out_l_w;
    logic                         sel_ok, run_hold, pass_en, ovl_any;

    assign src_h_a = bus.src_h;
    assign src_l_a = bus.src_l;

    // Out-of-range selects are ignored everywhere; the check vanishes when every code is a source.
    generate
        if ((1 << SEL_W) > N_SRC) begin : g_selchk
            assign sel_ok = (int'(bus.mode_sel) < N_SRC);
        end else begin : g_selall
            assign sel_ok = 1'b1;
        end
    endgenerate

    always_comb begin
        sel_h = '0;
        sel_l = '0;
        for (int s = 0; s < N_SRC; s++) begin
            if (active_q == SEL_W'(s)) begin
                sel_h = src_h_a[s];
                sel_l = src_l_a[s];
            end
        end
    end

    // Outputs pass only when RUN is kept on this edge; leaving RUN zeroes them on the same edge.
    assign run_hold = (state_q == ST_RUN) && bus.enable &&
                      !(sel_ok && (bus.mode_sel != active_q));
    assign pass_en  = run_hold && !fault_q;
    assign ovl_any  = (state_q == ST_RUN) && (|ovl);

    generate
        for (genvar g = 0; g < N_LEGS; g++) begin : g_leg
            spwm_leg_gate u_leg (
                .clk     (clk),
                .rst     (rst),
                .pass_i  (pass_en),
                .h_i     (sel_h[g]),
                .l_i     (sel_l[g]),
                .ovl_o   (ovl[g]),
                .out_h_o (out_h_w[g]),
                .out_l_o (out_l_w[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_OFF;
            target_q    <= '0;
            active_q    <= '0;
            cnt_q       <= '0;
            switching_q <= 1'b1;
            fault_q     <= 1'b0;
        end else begin
            // A new overlap beats a simultaneous clear.
            if (ovl_any)            fault_q <= 1'b1;
            else if (bus.fault_clr) fault_q <= 1'b0;

            case (state_q)
                ST_OFF: begin
                    switching_q <= 1'b1;
                    if (bus.enable && sel_ok) begin
                        target_q <= bus.mode_sel;
                        cnt_q    <= '0;
                        state_q  <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (!bus.enable) begin
                        state_q <= ST_OFF;
                    end else if (sel_ok && (bus.mode_sel != target_q)) begin
                        target_q <= bus.mode_sel;
                        cnt_q    <= '0;
                    end else if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                        active_q    <= target_q;
                        state_q     <= ST_RUN;
                        switching_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!bus.enable) begin
                        state_q     <= ST_OFF;
                        switching_q <= 1'b1;
                    end else if (sel_ok && (bus.mode_sel != active_q)) begin
                        target_q    <= bus.mode_sel;
                        cnt_q       <= '0;
                        state_q     <= ST_BLANK;
                        switching_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_OFF;
                    switching_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.out_h       = out_h_w;
    assign bus.out_l       = out_l_w;
    assign bus.active_mode = active_q;
    assign bus.switching   = switching_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_spwm_leg_mux.sv
// Directed and randomized checks of spwm_leg_mux against a cycle-level behavioural model.
module tb_spwm_leg_mux;
    localparam int NL = 3;
    localparam int NS = 2;
    localparam int SW = 2;
    localparam int BC = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spwm_leg_mux_if #(.N_LEGS(NL), .N_SRC(NS), .SEL_W(SW)) bus ();

    spwm_leg_mux #(
        .N_LEGS(NL), .N_SRC(NS), .SEL_W(SW), .BLANK_CYCLES(BC), .CNT_W(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: mode 0 = gates off, 1 = blanking, 2 = passing the selected source.
    int            m_mode, m_tgt, m_act, m_left;
    bit            m_fault;
    logic [NL-1:0] m_oh, m_ol;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mode = 0; m_tgt = 0; m_act = 0; m_left = 0; m_fault = 0;
        m_oh = '0;  m_ol = '0;
    endtask

    task automatic m_step();
        int            ms;
        bit            ok, nf;
        logic [NL-1:0] sh, sl, ov;
        ms = int'(bus.mode_sel);
        ok = (ms < NS);
        sh = NL'(bus.src_h >> (m_act * NL));
        sl = NL'(bus.src_l >> (m_act * NL));
        ov = sh & sl;
        nf = (m_mode == 2 && ov != 0) ? 1'b1 : (bus.fault_clr ? 1'b0 : m_fault);
        m_oh = '0;
        m_ol = '0;
        case (m_mode)
            0: if (bus.enable && ok) begin
                   m_tgt = ms; m_left = BC; m_mode = 1;
               end
            1: if (!bus.enable) m_mode = 0;
               else if (ok && ms != m_tgt) begin
                   m_tgt = ms; m_left = BC;
               end else begin
                   m_left--;
                   if (m_left == 0) begin m_act = m_tgt; m_mode = 2; end
               end
            default: if (!bus.enable) m_mode = 0;
               else if (ok && ms != m_act) begin
                   m_tgt = ms; m_left = BC; m_mode = 1;
               end else if (!m_fault) begin
                   m_oh = sh & ~ov;
                   m_ol = sl & ~ov;
               end
        endcase
        m_fault = nf;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".out_h"},  32'(bus.out_h),       32'(m_oh));
        chk({ctx, ".out_l"},  32'(bus.out_l),       32'(m_ol));
        chk({ctx, ".active"}, 32'(bus.active_mode), 32'(m_act));
        chk({ctx, ".sw"},     32'(bus.switching),   32'(m_mode != 2));
        chk({ctx, ".fault"},  32'(bus.fault),       32'(m_fault));
    endtask

    task automatic tick(input string ctx);
        @(posedge clk);
        if (rst) m_reset();
        else     m_step();
        #1;
        check_all(ctx);
    endtask

    task automatic set_src(input logic [NL-1:0] h1, input logic [NL-1:0] h0,
                           input logic [NL-1:0] l1, input logic [NL-1:0] l0);
        bus.src_h = {h1, h0};
        bus.src_l = {l1, l0};
    endtask

    initial begin
        rst = 1'b1;
        bus.enable = 1'b0; bus.mode_sel = '0; bus.fault_clr = 1'b0;
        bus.src_h = '0;    bus.src_l = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst.out_h", 32'(bus.out_h), 32'd0);
        chk("rst.out_l", 32'(bus.out_l), 32'd0);
        chk("rst.sw",    32'(bus.switching), 32'd1);
        chk("rst.fault", 32'(bus.fault), 32'd0);
        chk("rst.act",   32'(bus.active_mode), 32'd0);

        // Startup into mode 0.
        bus.enable = 1'b1; bus.mode_sel = 2'd0;
        set_src(3'b011, 3'b101, 3'b100, 3'b010);
        for (int i = 0; i < BC; i++) begin
            tick("start");
            chk("start.blank_h", 32'(bus.out_h), 32'd0);
        end
        tick("start");
        chk("start.commit_sw", 32'(bus.switching), 32'd0);
        chk("start.commit_h",  32'(bus.out_h), 32'd0);
        tick("start");
        chk("start.run_h", 32'(bus.out_h), 32'b101);
        chk("start.run_l", 32'(bus.out_l), 32'b010);

        // Switch to mode 1.
        bus.mode_sel = 2'd1;
        tick("sw");
        chk("sw.k_h",  32'(bus.out_h), 32'd0);
        chk("sw.k_sw", 32'(bus.switching), 32'd1);
        repeat (BC - 1) begin
            tick("sw");
            chk("sw.act_old", 32'(bus.active_mode), 32'd0);
        end
        tick("sw");
        chk("sw.act_new", 32'(bus.active_mode), 32'd1);
        tick("sw");
        chk("sw.run_h", 32'(bus.out_h), 32'b011);
        chk("sw.run_l", 32'(bus.out_l), 32'b100);

        // Back to mode 0, then retarget mid-blank.
        bus.mode_sel = 2'd0;
        repeat (BC + 2) tick("back");
        bus.mode_sel = 2'd1;
        repeat (2) tick("retgt");
        bus.mode_sel = 2'd0;
        tick("retgt");
        repeat (BC - 1) begin
            tick("retgt");
            chk("retgt.sw_hold", 32'(bus.switching), 32'd1);
            chk("retgt.act0",    32'(bus.active_mode), 32'd0);
        end
        tick("retgt");
        chk("retgt.run_sw", 32'(bus.switching), 32'd0);
        chk("retgt.act0b",  32'(bus.active_mode), 32'd0);
        tick("retgt");

        // Shoot-through on leg 1 of source 0.
        set_src(3'b011, 3'b111, 3'b100, 3'b010);
        tick("st");
        chk("st.edge_h", 32'(bus.out_h), 32'b101);
        chk("st.edge_l", 32'(bus.out_l), 32'b000);
        chk("st.fault",  32'(bus.fault), 32'd1);
        set_src(3'b011, 3'b101, 3'b100, 3'b010);
        tick("st");
        chk("st.hold_h", 32'(bus.out_h), 32'd0);
        bus.fault_clr = 1'b1;
        tick("st");
        chk("st.clr", 32'(bus.fault), 32'd0);
        bus.fault_clr = 1'b0;
        tick("st");
        chk("st.resume_h", 32'(bus.out_h), 32'b101);
        bus.fault_clr = 1'b1;
        set_src(3'b011, 3'b001, 3'b100, 3'b001);
        tick("st");
        chk("st.setwins", 32'(bus.fault), 32'd1);
        set_src(3'b011, 3'b101, 3'b100, 3'b010);
        tick("st");
        bus.fault_clr = 1'b0;
        tick("st");

        // Invalid select is ignored, then disable.
        bus.mode_sel = 2'd2;
        repeat (3) tick("inv");
        chk("inv.sw",  32'(bus.switching), 32'd0);
        chk("inv.act", 32'(bus.active_mode), 32'd0);
        chk("inv.h",   32'(bus.out_h), 32'b101);
        bus.enable = 1'b0;
        tick("dis");
        chk("dis.h",  32'(bus.out_h), 32'd0);
        chk("dis.sw", 32'(bus.switching), 32'd1);

        // Reach mode 1 with a fault, enter blanking, then async reset between edges.
        bus.enable = 1'b1; bus.mode_sel = 2'd1;
        repeat (BC + 2) tick("pre");
        set_src(3'b010, 3'b101, 3'b010, 3'b010);
        tick("pre");
        bus.mode_sel = 2'd0;
        set_src(3'b011, 3'b101, 3'b100, 3'b010);
        repeat (2) tick("pre");
        chk("pre.act1",  32'(bus.active_mode), 32'd1);
        chk("pre.fault", 32'(bus.fault), 32'd1);
        #2 rst = 1'b1;
        #1;
        m_reset();
        check_all("arst");
        #1 rst = 1'b0;

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            logic [NL*NS-1:0] h;
            bus.enable = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 11) == 0) bus.mode_sel = SW'($urandom_range(0, 3));
            h = (NL*NS)'($urandom);
            bus.src_h = h;
            bus.src_l = ($urandom_range(0, 7) == 0) ? (NL*NS)'($urandom) : ~h;
            bus.fault_clr = ($urandom_range(0, 5) == 0);
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
